uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Serial transmit stage of the UART core, directly downstream of the APB register slave. Takes the programmed baud value and transmit data byte, captures a byte on a load strobe into a one-entry holding register, and shifts it out LSB-first as start/data/optional-parity/stop on `tx`. Returns `tf_TXRDY` (holding register full) to the APB slave, which inverts it to form its `TX_RDY` status.

## Interface
- `BITWIDTH`, 8, data and baud-value width
- `OVERSAMPLE`, 16, baud ticks per serial bit

- `pclk`  in  1  system clock; all flops on rising edge
- `presetn`  in  1  asynchronous active-low reset
- `baud_val`  in  BITWIDTH  baud divisor; one baud tick every `baud_val+1` pclk cycles
- `data_in`  in  BITWIDTH  byte to transmit
- `tx_load`  in  1  one-cycle strobe; capture `data_in` into holding register
- `parity_en`  in  1  insert parity bit after data
- `parity_odd`  in  1  1 = odd parity, 0 = even
- `tx`  out  1  serial line, idles high
- `tf_TXRDY`  out  1  holding register full (1 = cannot accept)
- `tx_busy`  out  1  frame in progress (FSM not IDLE)
- `tx_overflow`  out  1  one-cycle pulse: load dropped because holding full

## Operation
- Reset: `tx`=1, `tf_TXRDY`=0, `tx_busy`=0, `tx_overflow`=0, FSM=IDLE, all counters 0, holding/shift registers 0.
- Holding register: `tx_load` with holding empty captures `data_in`, sets full. `tx_load` with holding full and no transfer that cycle: data dropped, holding unchanged, `tx_overflow` pulses.
- Transfer: holding to shift register when holding full and FSM is IDLE, or FSM is in the final tick of STOP (back-to-back frames, no idle gap). Transfer clears full. Simultaneous transfer and `tx_load`: old byte goes to shift, new byte captured, full remains 1, no overflow.
- `parity_en`/`parity_odd` are sampled at transfer; parity = XOR of the byte, inverted when odd. Changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START on transfer; `tx`=1 in IDLE.
  - START: `tx`=0 for one bit, then DATA.
  - DATA: `tx`=shift[0], shift right each bit; after bit index 7, go to PARITY if `parity_en`, else STOP.
  - PARITY: `tx`=parity bit for one bit, then STOP.
  - STOP: `tx`=1 for one bit, then START if transfer occurs, else IDLE.
- Bit timing: baud counter counts 0..`baud_val` and emits a tick on wrap. Sample counter counts ticks 0..OVERSAMPLE-1; bit ends on the tick where it equals OVERSAMPLE-1. Both counters are cleared on IDLE to START and run only while not IDLE.
- `baud_val` change mid-frame: the compare is `>= baud_val`, so a lowered value takes effect at once, with no wrap past 255. `baud_val`=0 gives a tick every cycle.

## Timing
- `tx_load` at edge N: `tf_TXRDY`=1 after N. Transfer at N+1 if idle, so `tf_TXRDY`=0 and `tx`=0 after N+1. The start bit begins 2 cycles after the strobe cycle.
- Bit period = OVERSAMPLE×(`baud_val`+1) pclk cycles exactly.
- Frame = (10 + `parity_en`) bit periods.
- `tx` and `tx_busy` are registered outputs (no combinational path from inputs).
- `tx_overflow` is registered and asserts the cycle after the dropped load.
- Reset mid-frame: `tx` returns to 1 immediately (async), the frame is aborted and the holding byte is discarded.

## Structure
- Shared package `uart_pkg`: FSM state enum (IDLE, START, DATA, PARITY, STOP), `OVERSAMPLE` default, `BITWIDTH` default. The same package serves the future RX block.
- Sub-module `uart_baud_gen`: baud counter plus tick output, with a clear input. It is reused by RX for 16× sampling.
- Top: holding register, shift register, bit index counter (3 bits), sample counter, FSM, parity logic.

## Test plan
- Reset then `baud_val`=0, load 0xA5, no parity: `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles; `tf_TXRDY` high for exactly 1 cycle; `tx_busy` high 160 cycles.
- `baud_val`=3, `parity_en`=1, odd, load 0x07: bit period 64 cycles; parity bit = 0; frame is 704 cycles.
- Back-to-back: load 0x55, then 0xAA during the first frame's DATA: the second start bit follows the first stop bit with zero idle cycles; `tf_TXRDY` drops at that boundary.
- Overflow: load 0x11, 0x22 (during frame, holding full), 0x33 before transfer: `tx_overflow` pulses once; output frames are 0x11 then 0x22; 0x33 is lost.
- Simultaneous transfer and load at the STOP final tick: no overflow; `tf_TXRDY` stays 1; three frames transmit in order.
- Assert `presetn` low in the middle of DATA: `tx`=1, `tf_TXRDY`=0 and `tx_busy`=0 at once. After release, a load of 0x3C transmits a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit/receive FSM states and default widths.
// The receive block imports this package as well.
package uart_pkg;

  localparam int UART_BITWIDTH   = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..baud_val_i while enabled and ticks on the wrap.
// The >= compare makes a lowered divisor take effect at once, with no wrap past the top.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_BITWIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] baud_val_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign tick_o = enable_i && (count_q >= baud_val_i);

  // NOTE: count_d gets its default before any branch, so the block never infers a latch.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = tick_o ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment only; blocking here races other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop
// shifter. A new frame can follow the stop bit with no idle gap.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int BITWIDTH   = UART_BITWIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic [BITWIDTH-1:0] baud_val,
  input  logic [BITWIDTH-1:0] data_in,
  input  logic                tx_load,
  input  logic                parity_en,
  input  logic                parity_odd,
  output logic                tx,
  output logic                tf_TXRDY,
  output logic                tx_busy,
  output logic                tx_overflow
);

  localparam int SCW  = $clog2(OVERSAMPLE);
  localparam int IDXW = $clog2(BITWIDTH);

  uart_state_e         state_q, state_d;
  logic [BITWIDTH-1:0] hold_q, hold_d;
  logic                full_q, full_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [SCW-1:0]      samp_q, samp_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic tick;
  logic bit_end;
  logic transfer;
  logic baud_clear;
  logic baud_run;

  assign baud_run   = (state_q != ST_IDLE);
  assign baud_clear = full_q && (state_q == ST_IDLE);

  uart_baud_gen #(
    .WIDTH (BITWIDTH)
  ) u_baud_gen (
    .clk        (pclk),
    .rst_n      (presetn),
    .clear_i    (baud_clear),
    .enable_i   (baud_run),
    .baud_val_i (baud_val),
    .tick_o     (tick)
  );

  assign bit_end  = tick && (samp_q == SCW'(OVERSAMPLE - 1));
  // The final stop tick doubles as a transfer slot so frames run back to back.
  assign transfer = full_q && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    full_d    = full_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    samp_d    = samp_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    ovf_d     = 1'b0;

    if (baud_clear) begin
      samp_d = '0;
    end else if (tick) begin
      samp_d = bit_end ? '0 : samp_q + 1'b1;
    end

    // A load in a transfer cycle refills the slot just vacated, so it never overflows.
    if (tx_load) begin
      if (!full_q || transfer) begin
        hold_d = data_in;
        full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (transfer) begin
      full_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (transfer) state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDXW'(BITWIDTH - 1)) begin
            idx_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) state_d = transfer ? ST_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (transfer) begin
      shift_d   = hold_q;
      idx_d     = '0;
      par_en_d  = parity_en;
      par_bit_d = (^hold_q) ^ parity_odd;
    end

    // Line level is derived from the next state so tx comes straight from a flop.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: every register, data included, is reset so an aborted frame leaves no stale byte.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      full_q    <= 1'b0;
      shift_q   <= '0;
      idx_q     <= '0;
      samp_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      samp_q    <= samp_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx          = tx_q;
  assign tf_TXRDY    = full_q;
  assign tx_busy     = busy_q;
  assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: table of single frames plus back-to-back,
// overflow, simultaneous load/transfer and mid-frame reset sequences.
module tb_uart_tx_core;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [7:0] baud_val;
  logic [7:0] data_in;
  logic       tx_load;
  logic       parity_en;
  logic       parity_odd;
  logic       tx;
  logic       tf_TXRDY;
  logic       tx_busy;
  logic       tx_overflow;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_core dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .baud_val    (baud_val),
    .data_in     (data_in),
    .tx_load     (tx_load),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .tx          (tx),
    .tf_TXRDY    (tf_TXRDY),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow)
  );

  always #5 pclk = ~pclk;

  // Frame levels in transmit order: bit 0 = start, bit nbits-1 = stop.
  typedef struct {
    logic [7:0]  bv;
    logic        pe;
    logic        po;
    logic [7:0]  data;
    logic [10:0] bits;
    int          nbits;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the sample point of frame cycle 0.
  task automatic start_load(input logic [7:0] d, input string tag);
    data_in = d;
    tx_load = 1'b1;
    @(negedge pclk);
    tx_load = 1'b0;
    check($sformatf("%s load {tf,tx,busy}", tag), {29'd0, tf_TXRDY, tx, tx_busy}, 32'b110);
    @(negedge pclk);
    check($sformatf("%s start {tf,tx,busy}", tag), {29'd0, tf_TXRDY, tx, tx_busy}, 32'b001);
  endtask

  // Follows one frame cycle by cycle; optional loads are driven for the edge after cycle la0/la1.
  task automatic frame_check(input logic [10:0] bits, input int nbits, input int bitp,
                             input int la0, input logic [7:0] ld0,
                             input int la1, input logic [7:0] ld1,
                             input string tag, output int ovf_seen);
    int bad_cycle = -1;
    int busy_bad  = 0;
    ovf_seen = 0;
    for (int c = 0; c < nbits * bitp; c++) begin
      if (tx !== bits[c / bitp] && bad_cycle < 0) bad_cycle = c;
      if (tx_busy !== 1'b1) busy_bad++;
      if (tx_overflow === 1'b1) ovf_seen++;
      if (c == la0) begin
        data_in = ld0;
        tx_load = 1'b1;
      end else if (c == la1) begin
        data_in = ld1;
        tx_load = 1'b1;
      end else begin
        tx_load = 1'b0;
      end
      @(negedge pclk);
    end
    tx_load = 1'b0;
    check($sformatf("%s first bad tx cycle", tag), bad_cycle, -1);
    check($sformatf("%s busy low cycles", tag), busy_bad, 0);
  endtask

  initial begin
    int ovf;
    int bad;

    presetn    = 1'b0;
    tx_load    = 1'b0;
    data_in    = 8'h00;
    baud_val   = 8'd0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    vecs[0] = '{8'd0, 1'b0, 1'b0, 8'hA5, 11'b0_1_10100101_0, 10};
    vecs[1] = '{8'd3, 1'b1, 1'b1, 8'h07, 11'b1_0_00000111_0, 11};
    vecs[2] = '{8'd1, 1'b1, 1'b0, 8'h3C, 11'b1_0_00111100_0, 11};
    vecs[3] = '{8'd0, 1'b1, 1'b0, 8'h01, 11'b1_1_00000001_0, 11};
    vecs[4] = '{8'd2, 1'b0, 1'b0, 8'hFF, 11'b0_1_11111111_0, 10};

    repeat (3) @(negedge pclk);
    check("reset {tx,tf,busy,ovf}", {28'd0, tx, tf_TXRDY, tx_busy, tx_overflow}, 32'b1000);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    check("idle {tx,tf,busy,ovf}", {28'd0, tx, tf_TXRDY, tx_busy, tx_overflow}, 32'b1000);

    // Single frames; parity controls flip after transfer and must not alter the frame.
    for (int i = 0; i < 5; i++) begin
      baud_val   = vecs[i].bv;
      parity_en  = vecs[i].pe;
      parity_odd = vecs[i].po;
      start_load(vecs[i].data, $sformatf("vec%0d", i));
      parity_en  = ~vecs[i].pe;
      parity_odd = ~vecs[i].po;
      frame_check(vecs[i].bits, vecs[i].nbits, 16 * (int'(vecs[i].bv) + 1),
                  -1, 8'h00, -1, 8'h00, $sformatf("vec%0d", i), ovf);
      check($sformatf("vec%0d overflow", i), ovf, 0);
      check($sformatf("vec%0d end {tx,tf,busy}", i), {29'd0, tx, tf_TXRDY, tx_busy}, 32'b100);
      repeat (3) @(negedge pclk);
    end

    baud_val   = 8'd0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Back-to-back: second byte loaded during first frame's data bits.
    start_load(8'h55, "b2b");
    frame_check(11'b0_1_01010101_0, 10, 16, 40, 8'hAA, -1, 8'h00, "b2b f1", ovf);
    check("b2b f1 overflow", ovf, 0);
    check("b2b boundary {tx,tf,busy}", {29'd0, tx, tf_TXRDY, tx_busy}, 32'b001);
    frame_check(11'b0_1_10101010_0, 10, 16, -1, 8'h00, -1, 8'h00, "b2b f2", ovf);
    check("b2b end {tx,tf,busy}", {29'd0, tx, tf_TXRDY, tx_busy}, 32'b100);
    repeat (3) @(negedge pclk);

    // Overflow: 0x22 fills the empty slot, 0x33 is dropped.
    start_load(8'h11, "ovf");
    frame_check(11'b0_1_00010001_0, 10, 16, 20, 8'h22, 40, 8'h33, "ovf f1", ovf);
    check("ovf pulse count", ovf, 1);
    check("ovf boundary {tx,tf,busy}", {29'd0, tx, tf_TXRDY, tx_busy}, 32'b001);
    frame_check(11'b0_1_00100010_0, 10, 16, -1, 8'h00, -1, 8'h00, "ovf f2", ovf);
    check("ovf f2 overflow", ovf, 0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tf_TXRDY !== 1'b0) bad++;
      @(negedge pclk);
    end
    check("ovf dropped byte not sent", bad, 0);

    // Load coincides with the stop-bit transfer: no overflow, holding stays full.
    start_load(8'h0F, "sim");
    frame_check(11'b0_1_00001111_0, 10, 16, 30, 8'h81, 159, 8'hC3, "sim f1", ovf);
    check("sim f1 overflow", ovf, 0);
    check("sim boundary1 {tx,tf,busy}", {29'd0, tx, tf_TXRDY, tx_busy}, 32'b011);
    frame_check(11'b0_1_10000001_0, 10, 16, -1, 8'h00, -1, 8'h00, "sim f2", ovf);
    check("sim f2 overflow", ovf, 0);
    check("sim boundary2 {tx,tf,busy}", {29'd0, tx, tf_TXRDY, tx_busy}, 32'b001);
    frame_check(11'b0_1_11000011_0, 10, 16, -1, 8'h00, -1, 8'h00, "sim f3", ovf);
    check("sim end {tx,tf,busy}", {29'd0, tx, tf_TXRDY, tx_busy}, 32'b100);
    repeat (3) @(negedge pclk);

    // Asynchronous reset in the middle of the data bits with a byte waiting.
    start_load(8'h96, "rst");
    repeat (30) @(negedge pclk);
    data_in = 8'h5A;
    tx_load = 1'b1;
    @(negedge pclk);
    tx_load = 1'b0;
    repeat (20) @(negedge pclk);
    check("rst pre {tf,busy}", {30'd0, tf_TXRDY, tx_busy}, 32'b11);
    #2 presetn = 1'b0;
    #1 check("rst async {tx,tf,busy,ovf}", {28'd0, tx, tf_TXRDY, tx_busy, tx_overflow}, 32'b1000);
    @(negedge pclk);
    presetn = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tf_TXRDY !== 1'b0) bad++;
      @(negedge pclk);
    end
    check("rst holding discarded", bad, 0);
    start_load(8'h3C, "post");
    frame_check(11'b0_1_00111100_0, 10, 16, -1, 8'h00, -1, 8'h00, "post", ovf);
    check("post end {tx,tf,busy}", {29'd0, tx, tf_TXRDY, tx_busy}, 32'b100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
